// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned SUB_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fsub_bit.sv
// One-bit full subtractor cell: x - y - bin, producing difference and borrow-out.
module fsub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit unsigned subtractor (A - B), LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned W = SUB_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned     CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic [W-1:0]     r_res_sh;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_bo;
    logic [W-1:0]     w_res_nxt;

    fsub_bit u_fsub (
        .x   (r_a_sh[0]),
        .y   (r_b_sh[0]),
        .bin (r_borrow),
        .d   (w_d),
        .bo  (w_bo)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    assign w_res_nxt = {w_d, r_res_sh[W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == RUN);
            r_done <= (w_state_nxt == DONE);
            if (w_load) begin
                r_a_sh   <= a;
                r_b_sh   <= b;
                r_res_sh <= '0;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
            end else if (w_step) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_res_sh <= w_res_nxt;
                r_borrow <= w_bo;
                r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            // Results only change when the final bit completes.
            if (w_last) begin
                r_diff <= w_res_nxt;
                r_bout <= w_bo;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_borrow ^ w_bo;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit unsigned subtractor computing A − B, LSB first, one bit per clock.
- Built around a single full-subtractor bit cell plus a registered borrow.
- Sits upstream of result consumers (ALU/accumulator datapaths). Trades area for latency versus a ripple array of full subtractors.
- Operands are parallel-loaded; results are parallel-unloaded via a start/busy/done handshake.

Parameters:
- W, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to load operands and begin; honoured only when not busy.
- a  input  W  minuend; sampled on the accepted start edge only.
- b  input  W  subtrahend; sampled on the accepted start edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when diff/bout become valid.
- diff  output  W  A − B mod 2^W.
- bout  output  1  final borrow; 1 iff A < B (unsigned).

Behaviour:
- Reset (sampled on a clk edge with rst=1): state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow reg=0, operand shift regs=0. Reset overrides start.
- Reset mid-operation aborts the operation: no done pulse, and diff/bout clear to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → load a/b shift regs, borrow=0, count=0, go to RUN.
  - RUN: each edge computes one bit from the LSBs of the shift regs and the borrow reg:
    - d = a0^b0^bin.
    - bo = (~a0&b0) | (~a0&bin) | (b0&bin).
    - d shifts into the MSB of the result shift reg; shift regs move right; borrow reg takes bo; count increments.
    - On the edge where count reaches W−1, the Wth bit completes: go to DONE, copy result to diff and final bo to bout.
  - DONE: done=1 for exactly this one cycle. Next edge: start=1 → reload and go to RUN (back-to-back); otherwise go to IDLE.
- busy=1 exactly in RUN. start is ignored while busy.
- a/b changes after acceptance do not affect the result.
- Latency: start accepted at edge E0 → done high in the cycle after edge EW (W RUN cycles). Throughput: one result per W+1 cycles.
- diff/bout hold their value from the DONE state until the next DONE or reset. They are not modified during RUN; internal shift regs only.
- Counter width: $clog2(W). No wrap beyond W−1.
- Boundaries:
  - A=B gives diff=0, bout=0.
  - A=0, B=2^W−1 gives diff=1, bout=1.
  - start held high continuously gives back-to-back operations with the DONE→RUN path.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), meaning signed two's-complement overflow of A − B.
  - ovf = borrow-in XOR borrow-out of the MSB bit step.
  - Registered alongside bout in DONE; reset 0; held like diff.
- Undefined: port absent; no additional logic.

Decomposition:
- Shared package serial_sub_pkg holds:
  - State enum typedef (IDLE, RUN, DONE).
  - Default width constant SUB_W_DEFAULT=8.
- Sub-module fsub_bit: pure combinational 1-bit full subtractor (inputs x, y, bin; outputs d, bo). Instantiated once in the datapath.
- Top holds the FSM, counter, shift registers and output registers.

Test Plan:
- W=8, rst high 2 cycles then low → busy=0, done=0, diff=0, bout=0. Start in the same cycle as rst=1 is ignored.
- a=0x5A, b=0x23, one-cycle start → busy for 8 cycles, done pulse in cycle 9, diff=0x37, bout=0.
- a=0x00, b=0xFF → diff=0x01, bout=1. a=0x80, b=0x80 → diff=0x00, bout=0.
- Start held high for 4 operations with a/b changing every cycle → each result matches the operands sampled on its accepted edge. Done pulses spaced 9 cycles apart; start during busy is ignored.
- rst asserted in the 4th RUN cycle of a=0xF0, b=0x0F → no done pulse, outputs 0. A following start with a=0x10, b=0x01 gives diff=0x0F, bout=0.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 → diff=0x7F, ovf=1. a=0x05, b=0x03 → ovf=0. Randomised 200 operand pairs are checked against a reference model (A−B, borrow, signed overflow).
